// File: rtl/change_dispense_ctrl.sv
// Change payout sequencer: breaks a change amount into 10/5/1 coins, largest first,
// and issues them one at a time to the hopper. Define CHANGE_INVENTORY_EN for coin inventory.
module change_dispense_ctrl #(
  parameter int AMT_W    = 8,
  parameter int INV_W    = 6,
  parameter int INV_INIT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  output logic             coin_valid,
  input  logic             coin_ready,
  output logic [1:0]       coin_denom,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic             refill
);

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, FIN, ERR} state_t;

  localparam logic [1:0] D1 = 2'b01, D5 = 2'b10, D10 = 2'b11;

  state_t           state, state_nxt;
  logic [AMT_W-1:0] remaining, rem_nxt, coin_val;
  logic [1:0]       denom_nxt;
  logic [2:0]       avail;   // {10,5,1} denomination may be offered
  logic             error_d;
  logic             issue_hs;

  assign issue_hs = (state == ISSUE) && coin_ready;

`ifdef CHANGE_INVENTORY_EN
  logic [INV_W-1:0] inv_1, inv_5, inv_10;

  assign avail   = {inv_10 != '0, inv_5 != '0, inv_1 != '0};
  assign error_d = (state_nxt == ERR);

  // refill has priority over a same-cycle payout; empty counters never wrap
  always_ff @(posedge clk) begin
    if (reset || refill) begin
      inv_1  <= INV_W'(INV_INIT);
      inv_5  <= INV_W'(INV_INIT);
      inv_10 <= INV_W'(INV_INIT);
    end else if (issue_hs) begin
      if (coin_denom == D1  && inv_1  != '0) inv_1  <= inv_1  - 1'b1;
      if (coin_denom == D5  && inv_5  != '0) inv_5  <= inv_5  - 1'b1;
      if (coin_denom == D10 && inv_10 != '0) inv_10 <= inv_10 - 1'b1;
    end
  end
`else
  logic        unused_refill;
  logic [31:0] unused_inv_cfg;

  assign avail          = 3'b111;
  assign error_d        = 1'b0;
  assign unused_refill  = refill;
  assign unused_inv_cfg = INV_W ^ INV_INIT;
`endif

  always_comb begin
    coin_val = '0;
    case (coin_denom)
      D1:      coin_val = AMT_W'(1);
      D5:      coin_val = AMT_W'(5);
      D10:     coin_val = AMT_W'(10);
      default: coin_val = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    denom_nxt = coin_denom;
    case (state)
      IDLE: if (req_valid) begin
        rem_nxt   = req_amount;
        state_nxt = (req_amount == '0) ? FIN : SELECT;
      end
      SELECT: begin
        state_nxt = ISSUE;
        if (remaining >= AMT_W'(10) && avail[2])     denom_nxt = D10;
        else if (remaining >= AMT_W'(5) && avail[1]) denom_nxt = D5;
        else if (remaining >= AMT_W'(1) && avail[0]) denom_nxt = D1;
        else begin
          state_nxt = ERR;
          rem_nxt   = '0;
        end
      end
      ISSUE: if (coin_ready) begin
        // SELECT only picks coins no larger than remaining, so no underflow
        rem_nxt   = remaining - coin_val;
        denom_nxt = 2'b00;
        state_nxt = (rem_nxt == '0) ? FIN : SELECT;
      end
      FIN:     state_nxt = IDLE;
      ERR: begin
        state_nxt = IDLE;
        rem_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs are flopped from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      coin_denom <= 2'b00;
      req_ready  <= 1'b1;
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      remaining  <= rem_nxt;
      coin_denom <= denom_nxt;
      req_ready  <= (state_nxt == IDLE);
      coin_valid <= (state_nxt == ISSUE);
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == FIN);
      error      <= error_d;
    end
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Randomized self-checking bench for change_dispense_ctrl against an arithmetic
// coin-count model (greedy split, optional inventory).
module tb_change_dispense_ctrl;
  localparam int AMT_W = 8, INV_W = 6, INV_INIT = 20;

  logic             clk, reset, req_valid, req_ready, coin_valid, coin_ready;
  logic             busy, done, error, refill;
  logic [AMT_W-1:0] req_amount;
  logic [1:0]       coin_denom;

  change_dispense_ctrl #(.AMT_W(AMT_W), .INV_W(INV_W), .INV_INIT(INV_INIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_amount(req_amount), .coin_valid(coin_valid), .coin_ready(coin_ready),
    .coin_denom(coin_denom), .busy(busy), .done(done), .error(error), .refill(refill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int m_inv[3];           // model inventory: [0]=1, [1]=5, [2]=10
  logic [1:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_refill();
    for (int i = 0; i < 3; i++) m_inv[i] = INV_INIT;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (req_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    check({tag, "_idle"}, req_ready, 1);
  endtask

  // pct: chance (0-100) of coin_ready per cycle; hold: cycles to stall the first coin
  task automatic run_req(input int amount, input int pct, input int hold, input string tag);
    int n10, n5, n1, left, ncoin, k, stall_cyc, hold_n;
    bit fin, saw_err, status_ok, stable_ok, stalled;
    logic [1:0] held;
    logic [1:0] exp_q[$];
`ifdef CHANGE_INVENTORY_EN
    n10 = (amount / 10 < m_inv[2]) ? amount / 10 : m_inv[2];
    n5  = ((amount - 10*n10) / 5 < m_inv[1]) ? (amount - 10*n10) / 5 : m_inv[1];
    n1  = (amount - 10*n10 - 5*n5 < m_inv[0]) ? amount - 10*n10 - 5*n5 : m_inv[0];
`else
    n10 = amount / 10;
    n5  = (amount % 10) / 5;
    n1  = amount % 5;
`endif
    left  = amount - 10*n10 - 5*n5 - n1;
    ncoin = n10 + n5 + n1;
    for (int i = 0; i < n10; i++) exp_q.push_back(2'b11);
    for (int i = 0; i < n5;  i++) exp_q.push_back(2'b10);
    for (int i = 0; i < n1;  i++) exp_q.push_back(2'b01);

    wait_idle(tag);
    req_valid  = 1'b1;
    req_amount = AMT_W'(amount);
    @(posedge clk); #1;
    req_valid = 1'b0;
    got_q.delete();
    fin = 0; saw_err = 0; status_ok = 1; stable_ok = 1; stalled = 0;
    held = 2'b00; k = 0; stall_cyc = 0; hold_n = hold;
    while (!fin && k < 3000) begin
      @(negedge clk); k++;
      if (done === 1'b1 || error === 1'b1) begin
        fin = 1;
        saw_err = (error === 1'b1);
        if (done === 1'b1 && error === 1'b1) status_ok = 0;
      end else begin
        if (busy !== 1'b1 || req_ready !== 1'b0) status_ok = 0;
        if (stalled && (coin_valid !== 1'b1 || coin_denom !== held)) stable_ok = 0;
        if (coin_valid === 1'b1 && hold_n > 0) begin
          coin_ready = 1'b0; hold_n--; stall_cyc++;
        end else
          coin_ready = ($urandom_range(0, 99) < pct);
        if (coin_valid === 1'b1 && coin_ready) got_q.push_back(coin_denom);
        stalled = (coin_valid === 1'b1) && !coin_ready;
        held    = coin_denom;
      end
    end
    coin_ready = 1'b1;
    check({tag, "_finished"}, fin, 1);
    check({tag, "_error"}, saw_err, (left != 0));
    check({tag, "_ncoins"}, got_q.size(), ncoin);
    for (int i = 0; i < ncoin && i < got_q.size(); i++)
      check($sformatf("%s_coin%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_status"}, status_ok, 1);
    check({tag, "_stable"}, stable_ok, 1);
    if (hold > 0 && ncoin > 0) check({tag, "_stall_cycles"}, stall_cyc, hold);
    if (pct == 100 && hold == 0)
      check({tag, "_latency"}, k, (left != 0) ? 2*ncoin + 2 : 2*ncoin + 1);
    @(negedge clk);
    check({tag, "_pulse_end"}, {done, error}, 0);
    check({tag, "_back_idle"}, {req_ready, busy}, 2'b10);
    m_inv[2] -= n10; m_inv[1] -= n5; m_inv[0] -= n1;
  endtask

  initial begin
    int nv, k;
    reset = 1'b1; req_valid = 1'b0; req_amount = '0; coin_ready = 1'b1; refill = 1'b0;
    model_refill();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {req_ready, coin_valid, coin_denom, busy, done, error}, 7'b1000000);
    reset = 1'b0;

    run_req(17, 100, 0, "t1_17");
    run_req(0,  100, 0, "t2_zero");
    run_req(5,  100, 5, "t3_stall");

    // reset during the second coin offer abandons the payout without done
    wait_idle("t4");
    coin_ready = 1'b1; req_valid = 1'b1; req_amount = AMT_W'(30);
    @(posedge clk); #1;
    req_valid = 1'b0;
    nv = 0; k = 0;
    while (nv < 2 && k < 20) begin
      @(negedge clk); k++;
      if (coin_valid === 1'b1) nv++;
    end
    check("t4_second_issue", nv, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_refill();
    @(negedge clk);
    check("t4_after_rst", {req_ready, coin_valid, coin_denom, busy, done, error}, 7'b1000000);
    run_req(1, 100, 0, "t4_one");

    run_req(3, 100, 0, "t6_a");
    run_req(3, 100, 0, "t6_b");

    for (int i = 0; i < 40; i++) begin
`ifdef CHANGE_INVENTORY_EN
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); refill = 1'b1;
        @(negedge clk); refill = 1'b0;
        model_refill();
      end
`endif
      run_req(($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 255),
              ($urandom_range(0, 2) == 0) ? 100 : $urandom_range(30, 99),
              $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
